// File: rtl/log_table_writer.sv
// log_table_writer
// Producer side of the iDFI log table. Each accepted record {ID, address, data}
// is written as three 32-bit words into a circular table in memory. The
// pointer to the next free entry is then published, and o_trigger pulses so
// the iDFI checker fetches the new record.
//
// Ports:
//   clk, rst           clock (rising edge), synchronous active-high reset
//   i_logValid         record valid from the instrumentation side
//   o_logReady         writer can accept a record (IDLE only)
//   i_logId            record ID field
//   i_logAddr          accessed-address field
//   i_logData          data field
//   o_memReq           memory write request
//   o_memAddr          memory write address
//   o_memWdata         memory write data
//   i_memAck           memory write accepted
//   o_logAddrptr       base address of the next entry to be written
//   o_trigger          one-cycle pulse when an entry is committed
//   o_wrapped          sticky: the table has wrapped at least once
//   o_busy             FSM not in IDLE
module log_table_writer #(
   parameter int                      N_ADDR_WIDTH      = 32,
   parameter int                      N_DATA_WIDTH      = 32,
   parameter logic [N_ADDR_WIDTH-1:0] LOGTABLE_ADDRINIT = 32'h1FEFF800,
   parameter logic [N_ADDR_WIDTH-1:0] LOGTABLE_ADDREND  = 32'h1FEFFBF0,
   parameter int                      N_IDLOG_TEMP      = 32,
   parameter int                      N_ADDRLOG_WIDTH   = 32,
   parameter int                      N_DATALOG_WIDTH   = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_logValid,
   output logic                       o_logReady,
   input  logic [N_IDLOG_TEMP-1:0]    i_logId,
   input  logic [N_ADDRLOG_WIDTH-1:0] i_logAddr,
   input  logic [N_DATALOG_WIDTH-1:0] i_logData,
   output logic                       o_memReq,
   output logic [N_ADDR_WIDTH-1:0]    o_memAddr,
   output logic [N_DATA_WIDTH-1:0]    o_memWdata,
   input  logic                       i_memAck,
   output logic [N_ADDR_WIDTH-1:0]    o_logAddrptr,
   output logic                       o_trigger,
   output logic                       o_wrapped,
   output logic                       o_busy
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WR_ID   = 3'd1,
      S_WR_ADDR = 3'd2,
      S_WR_DATA = 3'd3,
      S_COMMIT  = 3'd4
   } state_t;

   localparam logic [N_ADDR_WIDTH-1:0] ENTRY_BYTES = N_ADDR_WIDTH'(12);

   state_t                       state_q, state_d;
   logic                         ready_q, ready_d;
   logic [N_ADDR_WIDTH-1:0]      ptr_q, ptr_d;
   logic                         wrapped_q, wrapped_d;
   logic [N_IDLOG_TEMP-1:0]      id_q, id_d;
   logic [N_ADDRLOG_WIDTH-1:0]   addr_q, addr_d;
   logic [N_DATALOG_WIDTH-1:0]   data_q, data_d;

   // Control state is reset; the captured record fields are only meaningful
   // after a capture and need no reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         ready_q   <= 1'b0;
         ptr_q     <= LOGTABLE_ADDRINIT;
         wrapped_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ready_q   <= ready_d;
         ptr_q     <= ptr_d;
         wrapped_q <= wrapped_d;
      end
      id_q   <= id_d;
      addr_q <= addr_d;
      data_q <= data_d;
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      wrapped_d = wrapped_q;
      id_d      = id_q;
      addr_d    = addr_q;
      data_d    = data_q;
      case (state_q)
         S_IDLE: begin
            // ready_q is low in the first cycle after reset, so a record
            // offered then is held by the producer, not taken.
            if (ready_q && i_logValid) begin
               id_d    = i_logId;
               addr_d  = i_logAddr;
               data_d  = i_logData;
               state_d = S_WR_ID;
            end
         end
         S_WR_ID: begin
            if (i_memAck) state_d = S_WR_ADDR;
         end
         S_WR_ADDR: begin
            if (i_memAck) state_d = S_WR_DATA;
         end
         S_WR_DATA: begin
            // The pointer moves only here, so the reader never sees a
            // partially written entry.
            if (i_memAck) begin
               if (ptr_q == LOGTABLE_ADDREND) begin
                  ptr_d     = LOGTABLE_ADDRINIT;
                  wrapped_d = 1'b1;
               end else begin
                  ptr_d = ptr_q + ENTRY_BYTES;
               end
               state_d = S_COMMIT;
            end
         end
         S_COMMIT: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      // Registered ready: high exactly when the FSM sits in IDLE out of reset.
      ready_d = (state_d == S_IDLE);
   end

   // Memory-side outputs are decoded from state and captured fields only.
   always_comb begin
      o_memReq   = 1'b0;
      o_memAddr  = '0;
      o_memWdata = '0;
      case (state_q)
         S_WR_ID: begin
            o_memReq   = 1'b1;
            o_memAddr  = ptr_q;
            o_memWdata = N_DATA_WIDTH'(id_q);
         end
         S_WR_ADDR: begin
            o_memReq   = 1'b1;
            o_memAddr  = ptr_q + N_ADDR_WIDTH'(4);
            o_memWdata = N_DATA_WIDTH'(addr_q);
         end
         S_WR_DATA: begin
            o_memReq   = 1'b1;
            o_memAddr  = ptr_q + N_ADDR_WIDTH'(8);
            o_memWdata = N_DATA_WIDTH'(data_q);
         end
         default: begin
            o_memReq = 1'b0;
         end
      endcase
   end

   assign o_logReady   = ready_q;
   assign o_logAddrptr = ptr_q;
   assign o_wrapped    = wrapped_q;
   assign o_trigger    = (state_q == S_COMMIT);
   assign o_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_log_table_writer.sv
// Testbench for log_table_writer: directed table of records followed by a
// randomized run, checked against a transaction-level table model.
module tb_log_table_writer;

   localparam logic [31:0] INIT = 32'h1FEFF800;
   localparam int          N_ENTRIES = 85;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        i_logValid = 1'b0;
   logic        o_logReady;
   logic [31:0] i_logId = '0;
   logic [31:0] i_logAddr = '0;
   logic [31:0] i_logData = '0;
   logic        o_memReq;
   logic [31:0] o_memAddr;
   logic [31:0] o_memWdata;
   logic        i_memAck = 1'b0;
   logic [31:0] o_logAddrptr;
   logic        o_trigger;
   logic        o_wrapped;
   logic        o_busy;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int n_rec  = 0;          // records committed since the last reset
   int prev_acc = 0;
   bit prev_hold = 1'b0;

   log_table_writer dut (
      .clk(clk), .rst(rst),
      .i_logValid(i_logValid), .o_logReady(o_logReady),
      .i_logId(i_logId), .i_logAddr(i_logAddr), .i_logData(i_logData),
      .o_memReq(o_memReq), .o_memAddr(o_memAddr), .o_memWdata(o_memWdata),
      .i_memAck(i_memAck), .o_logAddrptr(o_logAddrptr),
      .o_trigger(o_trigger), .o_wrapped(o_wrapped), .o_busy(o_busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] id;
      logic [31:0] addr;
      logic [31:0] data;
      int          dly;       // ack wait per word, -1 = random 0..2
      bit          hold;      // keep i_logValid high after acceptance
      logic [31:0] exp_base;
   } vec_t;

   // Table model: entry n of the log lives at INIT + 12*(n mod 85).
   function automatic logic [31:0] model_ptr(input int n);
      return INIT + 32'(12 * (n % N_ENTRIES));
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Called and returning at a negedge.
   task automatic send(input logic [31:0] id, input logic [31:0] ad,
                       input logic [31:0] da, input int dly, input bit hold,
                       input logic [31:0] base);
      int waited = 0;
      int total = 0;
      int acc;
      logic [31:0] words [3];
      words[0] = id; words[1] = ad; words[2] = da;
      while (o_logReady !== 1'b1 && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (o_logReady !== 1'b1) begin
         chk("ready_timeout", 32'(o_logReady), 32'd1);
         return;
      end
      i_logId = id; i_logAddr = ad; i_logData = da; i_logValid = 1'b1;
      acc = cyc;
      if (prev_hold) chk("throughput", 32'(acc - prev_acc), 32'd5);
      prev_acc = acc;
      prev_hold = hold;
      @(negedge clk);
      if (!hold) i_logValid = 1'b0;
      for (int w = 0; w < 3; w++) begin
         int d;
         d = (dly < 0) ? int'($urandom_range(0, 2)) : dly;
         total += d;
         for (int k = 0; k <= d; k++) begin
            chk("mem_req", 32'(o_memReq), 32'd1);
            chk("mem_addr", o_memAddr, base + 32'(4 * w));
            chk("mem_wdata", o_memWdata, words[w]);
            chk("ready_busy", 32'(o_logReady), 32'd0);
            chk("trigger_early", 32'(o_trigger), 32'd0);
            chk("ptr_hold", o_logAddrptr, base);
            i_memAck = (k == d);
            @(negedge clk);
         end
      end
      i_memAck = 1'b0;
      chk("trigger", 32'(o_trigger), 32'd1);
      chk("commit_req", 32'(o_memReq), 32'd0);
      chk("ptr_next", o_logAddrptr, model_ptr(n_rec + 1));
      chk("wrapped", 32'(o_wrapped), 32'(n_rec + 1 >= N_ENTRIES));
      if (total == 0) chk("latency", 32'(cyc - acc), 32'd4);
      @(negedge clk);
      chk("trigger_once", 32'(o_trigger), 32'd0);
      chk("ready_again", 32'(o_logReady), 32'd1);
      chk("idle", 32'(o_busy), 32'd0);
      n_rec++;
   endtask

   task automatic do_reset();
      rst = 1'b1; i_logValid = 1'b1; i_memAck = 1'b0;   // rst must win over valid
      @(negedge clk);
      @(negedge clk);
      chk("rst_ready", 32'(o_logReady), 32'd0);
      chk("rst_req", 32'(o_memReq), 32'd0);
      chk("rst_addr", o_memAddr, 32'd0);
      chk("rst_wdata", o_memWdata, 32'd0);
      chk("rst_ptr", o_logAddrptr, INIT);
      chk("rst_trigger", 32'(o_trigger), 32'd0);
      chk("rst_wrapped", 32'(o_wrapped), 32'd0);
      chk("rst_busy", 32'(o_busy), 32'd0);
      rst = 1'b0; i_logValid = 1'b0;
      n_rec = 0; prev_hold = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", 32'(o_logReady), 32'd1);
      chk("post_rst_busy", 32'(o_busy), 32'd0);
   endtask

   vec_t vecs [5];

   initial begin
      logic [31:0] ptr_before;
      vecs[0] = '{32'h2,        32'h14,       32'h20,       0, 1'b0, 32'h1FEFF800};
      vecs[1] = '{32'hA5A5_0001, 32'h0000_1000, 32'hDEAD_BEEF, 3, 1'b0, 32'h1FEFF80C};
      vecs[2] = '{32'h11,       32'h22,       32'h33,       0, 1'b1, 32'h1FEFF818};
      vecs[3] = '{32'h44,       32'h55,       32'h66,       0, 1'b1, 32'h1FEFF824};
      vecs[4] = '{32'hFFFF_FFFF, 32'h0,        32'h8000_0001, 0, 1'b1, 32'h1FEFF830};

      @(negedge clk);
      do_reset();
      for (int i = 0; i < 5; i++)
         send(vecs[i].id, vecs[i].addr, vecs[i].data, vecs[i].dly, vecs[i].hold, vecs[i].exp_base);
      i_logValid = 1'b0;
      prev_hold = 1'b0;

      // Fill the whole table from a fresh reset and wrap once.
      do_reset();
      for (int i = 0; i < N_ENTRIES; i++)
         send($urandom, $urandom, $urandom, -1, 1'b0, model_ptr(n_rec));
      chk("wrap_ptr", o_logAddrptr, 32'h1FEFF800);
      chk("wrap_flag", 32'(o_wrapped), 32'd1);
      send($urandom, $urandom, $urandom, 0, 1'b0, 32'h1FEFF800);
      for (int i = 0; i < 3; i++)
         send($urandom, $urandom, $urandom, -1, 1'b0, model_ptr(n_rec));

      // Spurious ack while idle.
      ptr_before = o_logAddrptr;
      i_memAck = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("spur_busy", 32'(o_busy), 32'd0);
         chk("spur_req", 32'(o_memReq), 32'd0);
         chk("spur_ptr", o_logAddrptr, ptr_before);
         chk("spur_trigger", 32'(o_trigger), 32'd0);
      end
      i_memAck = 1'b0;
      @(negedge clk);

      // Reset while writing the address word.
      i_logId = 32'hCAFE; i_logAddr = 32'hBEEF; i_logData = 32'hF00D; i_logValid = 1'b1;
      @(negedge clk);
      i_logValid = 1'b0; i_memAck = 1'b1;
      @(negedge clk);
      chk("mid_addr", o_memAddr, ptr_before + 32'd4);
      i_memAck = 1'b0; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_req", 32'(o_memReq), 32'd0);
      chk("mid_ptr", o_logAddrptr, INIT);
      chk("mid_wrapped", 32'(o_wrapped), 32'd0);
      chk("mid_trigger", 32'(o_trigger), 32'd0);
      chk("mid_busy", 32'(o_busy), 32'd0);
      n_rec = 0; prev_hold = 1'b0;
      @(negedge clk);
      chk("mid_trigger2", 32'(o_trigger), 32'd0);
      send(32'h1234, 32'h5678, 32'h9ABC, 1, 1'b0, 32'h1FEFF800);
      send($urandom, $urandom, $urandom, -1, 1'b0, model_ptr(n_rec));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got cycle %0d, expected completion", cyc);
      $fatal(1, "timeout");
   end

endmodule
